flash_boot_loader: RTL and testbench
====================================

Name: flash_boot_loader

Overview:
- Copies the program image from external SPI NOR flash (s25fl128s, READ 0x03) into the RAM half of the instruction memory after reset, using that memory's write port (write/addr/data).
- Sits directly upstream of the instruction memory on its load port.
- Raises done_o when the copy is complete. Top level holds the core in reset until done_o=1.
- Not instantiated in NO_FLASH builds, where the RAM is preloaded instead.

Parameters:
- CLK_DIV, 2, SCK half-period in clk_i cycles (legal range ≥1).
- FLASH_BASE, 24'h000000, flash byte address of the first image byte.
- WORD_COUNT, 2048, number of 32-bit words copied (legal range 1..2048; 2048 = 8 KiB RAM).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- spi_cs_no  out  1  flash chip select, active low
- spi_sck_o  out  1  SPI clock, mode 0 (idles low)
- spi_mosi_o  out  1  command/address to flash
- spi_miso_i  in  1  data from flash
- write_o  out  1  one-cycle write strobe to instruction RAM
- addr_o  out  13  RAM byte address, word aligned ([1:0]=0)
- data_o  out  32  RAM write data
- done_o  out  1  image loaded, sticky until reset

Behaviour:
- Reset values (async, rst_ni=0): spi_cs_no=1, spi_sck_o=0, spi_mosi_o=0, write_o=0, addr_o=0, data_o=0, done_o=0. All counters and the FSM return to IDLE.
- FSM states: IDLE -> CS_SETUP -> CMD -> ADDR -> DATA -> CS_HOLD -> DONE.
- IDLE: on the first clk_i edge after rst_ni rises, drive spi_cs_no=0 and go to CS_SETUP. No start input; a transfer starts once per reset.
- CS_SETUP:
  - Wait CLK_DIV cycles with SCK low.
  - spi_mosi_o already shows the first command bit.
- Bit timing, one bit per 2*CLK_DIV cycles:
  - SCK low phase of CLK_DIV cycles, then SCK high phase of CLK_DIV cycles.
  - spi_mosi_o changes only on the clk edge that drives SCK low (or at CS_SETUP entry).
  - spi_miso_i is sampled on the clk edge that drives SCK high.
- CMD: 8 bits of 0x03, MSB first.
- ADDR: 24 bits of FLASH_BASE, MSB first. spi_mosi_o=0 after ADDR.
- DATA: continuous read with CS held low for all WORD_COUNT*32 bits.
  - Each byte is received MSB first.
  - Little-endian word assembly: first byte of a word goes to data_o[7:0], fourth byte to [31:24].
  - On the clk edge that samples a word's 32nd bit: data_o<=assembled word, addr_o<=word_index*4, write_o<=1 for exactly one cycle.
  - data_o and addr_o hold until the next write.
  - word_index counts 0..WORD_COUNT-1.
- After the last word's 32nd bit: SCK returns low after its high phase, then CS_HOLD waits CLK_DIV cycles. Then spi_cs_no<=1 and the FSM goes to DONE.
- DONE:
  - done_o<=1 on the same edge spi_cs_no rises.
  - SCK stays low.
  - No further writes.
  - The FSM stays here until reset.
- Timing:
  - SCK rising edges total exactly 32+32*WORD_COUNT.
  - write_o pulses total exactly WORD_COUNT, spaced 64*CLK_DIV cycles apart.
- Reset mid-operation: all outputs go immediately to their reset values (CS deasserts asynchronously). A partial word is never written. On the next reset release the copy restarts from FLASH_BASE and word 0.
- write_o is never asserted while done_o=1 or in IDLE/CMD/ADDR.
- Width rules: bit counter 5 bits within a word; word counter 12 bits (can reach 2048); addr_o = word_index[10:0]<<2, which never wraps for legal WORD_COUNT.

Test Plan:
- CLK_DIV=2, WORD_COUNT=4, flash model bytes 00..0F -> MOSI carries 0x03,0x000000 on the first 32 SCK rises. Writes are (0x0000,0x03020100), (0x0004,0x07060504), (0x0008,0x0B0A0908), (0x000C,0x0F0E0D0C). done_o rises after the 4th write; CS is low for the whole transfer.
- FLASH_BASE=24'h010000, WORD_COUNT=1, model returns DE AD BE EF at 0x010000 -> address bits on MOSI = 0x010000. A single write of 0xEFBEADDE to addr 0x0000.
- CLK_DIV=1 and CLK_DIV=5 -> each SCK high/low phase lasts exactly CLK_DIV cycles. Consecutive write_o pulses are 64*CLK_DIV cycles apart. Total SCK rises = 32+32*WORD_COUNT.
- Assert rst_ni mid-way through word 2 -> CS=1, SCK=0, write_o=0 immediately, with no write for word 2. After release the command is resent and the first write is again (0x0000,0x03020100).
- After done_o=1, run 1000 cycles with the MISO pattern toggling -> no write_o, CS stays 1, done_o stays 1.
- WORD_COUNT=2048 -> last write at addr 0x1FFC, exactly 2048 write_o pulses.

Source files
------------

// File: rtl/flash_boot_loader_if.sv
// Instruction-RAM load port driven by the flash boot loader.
// The loader is the master; the instruction memory write port is the slave.
interface flash_boot_loader_if;
  logic        write_o;
  logic [12:0] addr_o;
  logic [31:0] data_o;

  modport master (output write_o, addr_o, data_o);
  modport slave  (input  write_o, addr_o, data_o);
endinterface

// File: rtl/flash_boot_loader.sv
// Copies WORD_COUNT little-endian words from SPI NOR flash (READ 0x03, mode 0)
// into instruction RAM after reset, then raises a sticky done_o.
module flash_boot_loader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int unsigned WORD_COUNT = 2048
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                spi_cs_no,
  output logic                spi_sck_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i,
  flash_boot_loader_if.master ram,
  output logic                done_o
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [31:0]     CMD_ADDR = {8'h03, FLASH_BASE};
  localparam logic [11:0]     LAST_WORD = 12'(WORD_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, ADDR, DATA, CS_HOLD, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [4:0]         bit_q, bit_d;
  logic [11:0]        word_q, word_d;
  logic [31:0]        tx_q, tx_d;
  logic [31:0]        rx_q, rx_d;
  logic               cs_n_q, cs_n_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               write_q, write_d;
  logic [12:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               done_q, done_d;
  logic [31:0]        rx_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign rx_next = {rx_q[30:0], spi_miso_i};

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    word_d  = word_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: begin
        cs_n_d  = 1'b0;
        tx_d    = CMD_ADDR;
        mosi_d  = CMD_ADDR[31];
        div_d   = '0;
        bit_d   = '0;
        word_d  = '0;
        state_d = CS_SETUP;
      end

      CS_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = CMD;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      CMD, ADDR, DATA: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else if (sck_q) begin
          // Falling edge: shift out the next command/address bit (zeros after ADDR).
          div_d  = '0;
          sck_d  = 1'b0;
          tx_d   = {tx_q[30:0], 1'b0};
          mosi_d = tx_q[30];
        end else begin
          // Rising edge: this edge completes the current bit.
          div_d = '0;
          sck_d = 1'b1;
          bit_d = bit_q + 1'b1;
          if (state_q == CMD && bit_q == 5'd7) begin
            bit_d   = '0;
            state_d = ADDR;
          end else if (state_q == ADDR && bit_q == 5'd23) begin
            bit_d   = '0;
            state_d = DATA;
          end else if (state_q == DATA) begin
            rx_d = rx_next;
            if (bit_q == 5'd31) begin
              // First received byte lands in the least significant lane.
              data_d  = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
              addr_d  = {word_q[10:0], 2'b00};
              write_d = 1'b1;
              word_d  = word_q + 1'b1;
              if (word_q == LAST_WORD) begin
                state_d = CS_HOLD;
              end
            end
          end
        end
      end

      CS_HOLD: begin
        // Finish the last high phase, then hold CS low for one more phase.
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else if (sck_q) begin
          div_d  = '0;
          sck_d  = 1'b0;
          mosi_d = 1'b0;
        end else begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        sck_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign spi_cs_no   = cs_n_q;
  assign spi_sck_o   = sck_q;
  assign spi_mosi_o  = mosi_q;
  assign ram.write_o = write_q;
  assign ram.addr_o  = addr_q;
  assign ram.data_o  = data_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench for flash_boot_loader: three parameter sets, each with a
// behavioural SPI flash and a bus monitor; expectations are hand-computed.
module tb_flash_boot_loader;

  logic       clk = 1'b0;
  logic [2:0] rst_n = '0;
  logic [2:0] cs_w, sck_w, mosi_w, miso_w, done_w;
  logic       tgl = 1'b0;
  logic       tgl_en = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tgl <= ~tgl;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h010000: flash_byte = 8'hDE;
      24'h010001: flash_byte = 8'hAD;
      24'h010002: flash_byte = 8'hBE;
      24'h010003: flash_byte = 8'hEF;
      default:    flash_byte = a[7:0];
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned CD   = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    localparam int unsigned WC   = (g == 0) ? 4 : (g == 1) ? 1 : 2;
    localparam logic [23:0] BASE = (g == 1) ? 24'h010000 : 24'h000000;

    flash_boot_loader_if ram ();

    flash_boot_loader #(
      .CLK_DIV   (CD),
      .FLASH_BASE(BASE),
      .WORD_COUNT(WC)
    ) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n[g]),
      .spi_cs_no (cs_w[g]),
      .spi_sck_o (sck_w[g]),
      .spi_mosi_o(mosi_w[g]),
      .spi_miso_i(miso_w[g]),
      .ram       (ram),
      .done_o    (done_w[g])
    );

    // Flash model: latches command+address, then streams bytes on SCK falls.
    logic        prev_sck = 1'b0;
    logic        miso_m = 1'b0;
    logic [31:0] f_cmdaddr = '0;
    int          f_rises = 0;
    int          dbit;
    logic [7:0]  fb;

    always @(negedge cs_w[g] or posedge sck_w[g] or negedge sck_w[g]) begin
      if (sck_w[g] !== prev_sck) begin
        prev_sck = sck_w[g];
        if (!cs_w[g]) begin
          if (sck_w[g]) begin
            if (f_rises < 32) f_cmdaddr = {f_cmdaddr[30:0], mosi_w[g]};
            f_rises++;
          end else if (f_rises >= 32) begin
            dbit   = f_rises - 32;
            fb     = flash_byte(f_cmdaddr[23:0] + 24'(dbit / 8));
            miso_m = fb[7 - (dbit % 8)];
          end
        end
      end else begin
        f_rises = 0;
        miso_m  = 1'b0;
      end
    end

    assign miso_w[g] = miso_m ^ (tgl_en & tgl);

    // Bus monitor, sampled on the inactive clock edge.
    int          cyc, tog_cyc, ph_min, ph_max, rises, wr_n, sp_min, sp_max, last_wr, cs_rise;
    logic        last_sck, last_cs, have_tog;
    logic [31:0] mosi_cap;
    logic [12:0] wr_addr [8];
    logic [31:0] wr_data [8];

    always @(negedge clk) begin
      if (!rst_n[g]) begin
        cyc = 0; have_tog = 1'b0; ph_min = 99999; ph_max = 0; rises = 0;
        wr_n = 0; sp_min = 99999; sp_max = 0; cs_rise = 0; mosi_cap = '0;
        last_sck = sck_w[g]; last_cs = cs_w[g];
      end else begin
        cyc++;
        if (sck_w[g] !== last_sck) begin
          if (have_tog) begin
            if (cyc - tog_cyc < ph_min) ph_min = cyc - tog_cyc;
            if (cyc - tog_cyc > ph_max) ph_max = cyc - tog_cyc;
          end
          have_tog = 1'b1;
          tog_cyc  = cyc;
          if (sck_w[g]) begin
            if (rises < 32) mosi_cap = {mosi_cap[30:0], mosi_w[g]};
            rises++;
          end
        end
        if (cs_w[g] && !last_cs) cs_rise++;
        if (ram.write_o) begin
          if (wr_n < 8) begin
            wr_addr[wr_n] = ram.addr_o;
            wr_data[wr_n] = ram.data_o;
          end
          if (wr_n > 0) begin
            if (cyc - last_wr < sp_min) sp_min = cyc - last_wr;
            if (cyc - last_wr > sp_max) sp_max = cyc - last_wr;
          end
          last_wr = cyc;
          wr_n++;
        end
        last_sck = sck_w[g];
        last_cs  = cs_w[g];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int unsigned g, input string tag);
    int unsigned n = 0;
    while (done_w[g] !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(done_w[g]), 64'd1);
  endtask

  int unsigned n;
  int          saved_wr;
  int          cs_low_seen;
  int          wr_before;

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("rst_cs",    64'(cs_w[0]),           64'd1);
    chk("rst_sck",   64'(sck_w[0]),          64'd0);
    chk("rst_mosi",  64'(mosi_w[0]),         64'd0);
    chk("rst_write", 64'(g_dut[0].ram.write_o), 64'd0);
    chk("rst_addr",  64'(g_dut[0].ram.addr_o),  64'd0);
    chk("rst_data",  64'(g_dut[0].ram.data_o),  64'd0);
    chk("rst_done",  64'(done_w),            64'd0);

    @(negedge clk);
    rst_n = '1;
    wait_done(0, "a_done");
    wait_done(1, "b_done");
    wait_done(2, "c_done");
    repeat (4) @(negedge clk);

    // A: CLK_DIV=2, 4 words from address 0
    chk("a_mosi_cmd", 64'(g_dut[0].mosi_cap), 64'h03000000);
    chk("a_wr_n",     64'(g_dut[0].wr_n),     64'd4);
    chk("a_addr0", 64'(g_dut[0].wr_addr[0]), 64'h0000);
    chk("a_data0", 64'(g_dut[0].wr_data[0]), 64'h03020100);
    chk("a_addr1", 64'(g_dut[0].wr_addr[1]), 64'h0004);
    chk("a_data1", 64'(g_dut[0].wr_data[1]), 64'h07060504);
    chk("a_addr2", 64'(g_dut[0].wr_addr[2]), 64'h0008);
    chk("a_data2", 64'(g_dut[0].wr_data[2]), 64'h0B0A0908);
    chk("a_addr3", 64'(g_dut[0].wr_addr[3]), 64'h000C);
    chk("a_data3", 64'(g_dut[0].wr_data[3]), 64'h0F0E0D0C);
    chk("a_rises",   64'(g_dut[0].rises),   64'd160);
    chk("a_cs_rise", 64'(g_dut[0].cs_rise), 64'd1);
    chk("a_ph_min",  64'(g_dut[0].ph_min),  64'd2);
    chk("a_ph_max",  64'(g_dut[0].ph_max),  64'd2);
    chk("a_sp_min",  64'(g_dut[0].sp_min),  64'd128);
    chk("a_sp_max",  64'(g_dut[0].sp_max),  64'd128);
    chk("a_cs_end",  64'(cs_w[0]),          64'd1);
    chk("a_sck_end", 64'(sck_w[0]),         64'd0);

    // B: CLK_DIV=1, one word from 0x010000
    chk("b_mosi_cmd", 64'(g_dut[1].mosi_cap),   64'h03010000);
    chk("b_wr_n",     64'(g_dut[1].wr_n),       64'd1);
    chk("b_addr0",    64'(g_dut[1].wr_addr[0]), 64'h0000);
    chk("b_data0",    64'(g_dut[1].wr_data[0]), 64'hEFBEADDE);
    chk("b_rises",    64'(g_dut[1].rises),      64'd64);
    chk("b_ph_min",   64'(g_dut[1].ph_min),     64'd1);
    chk("b_ph_max",   64'(g_dut[1].ph_max),     64'd1);

    // C: CLK_DIV=5, two words
    chk("c_wr_n",   64'(g_dut[2].wr_n),       64'd2);
    chk("c_data0",  64'(g_dut[2].wr_data[0]), 64'h03020100);
    chk("c_addr1",  64'(g_dut[2].wr_addr[1]), 64'h0004);
    chk("c_data1",  64'(g_dut[2].wr_data[1]), 64'h07060504);
    chk("c_rises",  64'(g_dut[2].rises),      64'd96);
    chk("c_ph_min", 64'(g_dut[2].ph_min),     64'd5);
    chk("c_ph_max", 64'(g_dut[2].ph_max),     64'd5);
    chk("c_sp",     64'(g_dut[2].sp_max),     64'd320);

    // After done: toggling MISO must not provoke any activity
    tgl_en      = 1'b1;
    wr_before   = g_dut[0].wr_n;
    cs_low_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cs_w[0] !== 1'b1 || done_w[0] !== 1'b1 || g_dut[0].ram.write_o !== 1'b0) cs_low_seen++;
    end
    tgl_en = 1'b0;
    chk("idle_wr_n",  64'(g_dut[0].wr_n), 64'(wr_before));
    chk("idle_quiet", 64'(cs_low_seen),   64'd0);

    // Restart A, then reset it half-way through word 2
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    n = 0;
    while (g_dut[0].wr_n < 2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_w2", 64'(g_dut[0].wr_n), 64'd2);
    repeat (64) @(negedge clk);
    saved_wr = g_dut[0].wr_n;
    rst_n[0] = 1'b0;
    #1;
    chk("mid_wr_n",  64'(saved_wr),              64'd2);
    chk("mid_cs",    64'(cs_w[0]),               64'd1);
    chk("mid_sck",   64'(sck_w[0]),              64'd0);
    chk("mid_write", 64'(g_dut[0].ram.write_o),  64'd0);
    chk("mid_addr",  64'(g_dut[0].ram.addr_o),   64'd0);
    chk("mid_done",  64'(done_w[0]),             64'd0);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    wait_done(0, "re_done");
    chk("re_mosi_cmd", 64'(g_dut[0].mosi_cap),   64'h03000000);
    chk("re_addr0",    64'(g_dut[0].wr_addr[0]), 64'h0000);
    chk("re_data0",    64'(g_dut[0].wr_data[0]), 64'h03020100);
    chk("re_wr_n",     64'(g_dut[0].wr_n),       64'd4);
    chk("re_data3",    64'(g_dut[0].wr_data[3]), 64'h0F0E0D0C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
